// File: rtl/aes_ctrl_pkg.sv
// Shared types, constants and FIPS-197 example vectors for the iterative AES controller.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} aes_fsm_t;

    localparam int NR_128    = 10;
    localparam int NR_192    = 12;
    localparam int NR_256    = 14;
    localparam int AES_BLK_W = 128;
    localparam int LAT_CNT_W = 4;

    // Keys are left-aligned in 256 bits so all three key sizes share one type.
    localparam logic [AES_BLK_W-1:0] FIPS_PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0]         FIPS_C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [AES_BLK_W-1:0] FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0]         FIPS_C2_KEY = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [AES_BLK_W-1:0] FIPS_C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0]         FIPS_C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [AES_BLK_W-1:0] FIPS_C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

endpackage

// File: rtl/aes_lat_timer.sv
// Round-datapath latency timer: loads to 1 on issue, counts while waiting,
// and flags the cycle in which the datapath result is valid.
module aes_lat_timer
    import aes_ctrl_pkg::*;
#(
    parameter int DP_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic lat_done
);

    logic [LAT_CNT_W-1:0] lat_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt <= '0;
        end else if (load) begin
            lat_cnt <= LAT_CNT_W'(1);
        end else if (en) begin
            lat_cnt <= lat_cnt + LAT_CNT_W'(1);
        end
    end

    assign lat_done = (lat_cnt == LAT_CNT_W'(DP_LAT));

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: initial AddRoundKey in-house, then NR
// issues to an external fixed-latency round datapath, one round key per issue.
module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int NR     = 10,
    parameter int DP_LAT = 2,
    parameter int RKW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_block,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_block,
    output logic [RKW-1:0]       rk_idx,
    input  logic [AES_BLK_W-1:0] rk_data,
    output logic                 dp_valid,
    output logic [AES_BLK_W-1:0] dp_state,
    output logic [AES_BLK_W-1:0] dp_key,
    output logic                 dp_last,
    input  logic [AES_BLK_W-1:0] dp_result,
    output logic                 busy
);

    aes_fsm_t             fsm;
    logic [RKW-1:0]       round;
    logic [AES_BLK_W-1:0] state_reg;
    logic                 lat_load;
    logic                 lat_en;
    logic                 lat_done;
    logic                 round_last;

    assign lat_load   = (fsm == ISSUE);
    assign lat_en     = (fsm == WAIT);
    assign round_last = (round == RKW'(NR));

    aes_lat_timer #(.DP_LAT(DP_LAT)) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .en       (lat_en),
        .lat_done (lat_done)
    );

    // Handshake/issue flags are registered alongside the state so they toggle on the transition edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            round     <= '0;
            state_reg <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dp_valid  <= 1'b0;
            dp_last   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_block ^ rk_data;
                        round     <= RKW'(1);
                        fsm       <= ISSUE;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        dp_valid  <= 1'b1;
                        dp_last   <= (NR == 1);
                    end
                end
                ISSUE: begin
                    fsm      <= WAIT;
                    dp_valid <= 1'b0;
                    dp_last  <= 1'b0;
                end
                WAIT: begin
                    if (lat_done) begin
                        state_reg <= dp_result;
                        if (round_last) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            round    <= round + RKW'(1);
                            fsm      <= ISSUE;
                            dp_valid <= 1'b1;
                            dp_last  <= (round + RKW'(1) == RKW'(NR));
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        round     <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign rk_idx    = round;
    assign dp_state  = state_reg;
    assign dp_key    = rk_data;
    assign out_block = out_valid ? state_reg : '0;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: three parameterisations, each with a behavioural
// key store and round datapath; results checked against an AES reference model.
module tb_aes_round_sequencer;
    import aes_ctrl_pkg::*;

    localparam int NCFG = 3;
    localparam int CFG_NR  [NCFG] = '{10, 10, 14};
    localparam int CFG_LAT [NCFG] = '{2, 1, 4};

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_block = '0;
    logic         out_ready = 1'b0;
    int           sel = 0;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    logic         in_ready_a  [NCFG];
    logic         out_valid_a [NCFG];
    logic [127:0] out_block_a [NCFG];
    logic [3:0]   rk_idx_a    [NCFG];
    logic [127:0] rk_data_a   [NCFG];
    logic         dp_valid_a  [NCFG];
    logic [127:0] dp_state_a  [NCFG];
    logic [127:0] dp_key_a    [NCFG];
    logic [127:0] dp_result_a [NCFG];
    logic         dp_last_a   [NCFG];
    logic         busy_a      [NCFG];
    logic [127:0] rk_mem      [NCFG][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   s0, s1, s2, s3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(st[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) b[rr + 4*c] = a[rr + 4*((c + rr) % 4)];
        for (int c = 0; c < 4; c++) begin
            s0 = b[4*c]; s1 = b[4*c+1]; s2 = b[4*c+2]; s3 = b[4*c+3];
            if (last) begin
                a[4*c] = s0; a[4*c+1] = s1; a[4*c+2] = s2; a[4*c+3] = s3;
            end else begin
                a[4*c]   = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
                a[4*c+1] = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
                a[4*c+2] = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
                a[4*c+3] = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
            end
        end
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = a[i];
        return r ^ key;
    endfunction

    function automatic logic [127:0] ref_encrypt(input int k, input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ rk_mem[k][0];
        for (int r = 1; r <= nr; r++) s = aes_round(s, rk_mem[k][r], r == nr);
        return s;
    endfunction

    // Key store: FIPS-197 key expansion; unused slots get junk so a stray index shows up.
    task automatic load_key(input int k, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xtime(rcon);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subword(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 16; r++) rk_mem[k][r] = {$urandom, $urandom, $urandom, $urandom};
        for (int r = 0; r <= nk + 6; r++) rk_mem[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- DUT instances with behavioural datapath ----------------
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        logic [127:0] pipe [16];

        aes_round_sequencer #(.NR(CFG_NR[g]), .DP_LAT(CFG_LAT[g]), .RKW(4)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid && (sel == g)),
            .in_ready  (in_ready_a[g]),
            .in_block  (in_block),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready && (sel == g)),
            .out_block (out_block_a[g]),
            .rk_idx    (rk_idx_a[g]),
            .rk_data   (rk_data_a[g]),
            .dp_valid  (dp_valid_a[g]),
            .dp_state  (dp_state_a[g]),
            .dp_key    (dp_key_a[g]),
            .dp_last   (dp_last_a[g]),
            .dp_result (dp_result_a[g]),
            .busy      (busy_a[g])
        );

        assign rk_data_a[g]   = rk_mem[g][rk_idx_a[g]];
        assign dp_result_a[g] = pipe[CFG_LAT[g]-1];

        always @(posedge clk) begin
            pipe[0] <= dp_valid_a[g] ? aes_round(dp_state_a[g], dp_key_a[g], dp_last_a[g])
                                     : {$urandom, $urandom, $urandom, $urandom};
            for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
        end
    end

    logic         in_ready_s, out_valid_s, dp_valid_s, dp_last_s, busy_s;
    logic [127:0] out_block_s;
    logic [3:0]   rk_idx_s;

    always_comb begin
        in_ready_s  = in_ready_a[sel];
        out_valid_s = out_valid_a[sel];
        dp_valid_s  = dp_valid_a[sel];
        dp_last_s   = dp_last_a[sel];
        busy_s      = busy_a[sel];
        out_block_s = out_block_a[sel];
        rk_idx_s    = rk_idx_a[sel];
    end

    int   mon_idx  [$];
    logic mon_last [$];
    always @(negedge clk) begin
        if (dp_valid_s) begin
            mon_idx.push_back(int'(rk_idx_s));
            mon_last.push_back(dp_last_s);
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] pt, output int acc);
        acc = -1;
        in_block = pt;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            if (in_ready_s) acc = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int done);
        done = -1;
        for (int i = 0; i < 400 && done < 0; i++) begin
            if (out_valid_s) done = cyc;
            else tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [4:0] obs;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            obs = {in_ready_a[k], out_valid_a[k], dp_valid_a[k], dp_last_a[k], busy_a[k]};
            checks++;
            if (obs !== 5'b10000) begin
                errors++;
                $display("FAIL reset_flags[%0d]: {in_ready,out_valid,dp_valid,dp_last,busy}=%b expected 10000", k, obs);
            end
            checks++;
            if (rk_idx_a[k] !== 4'd0) begin
                errors++;
                $display("FAIL reset_rk_idx[%0d]: got %0d expected 0", k, rk_idx_a[k]);
            end
            checks++;
            if (out_block_a[k] !== 128'h0) begin
                errors++;
                $display("FAIL reset_out_block[%0d]: got %h expected 0", k, out_block_a[k]);
            end
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        logic [127:0] ct;
        int acc, done, bad;
        sel = 0;
        out_ready = 1'b1;
        mon_idx.delete();
        mon_last.delete();
        checks++;
        if (rk_idx_s !== 4'd0) begin
            errors++;
            $display("FAIL nominal_idle_rk_idx: got %0d expected 0", rk_idx_s);
        end
        send(FIPS_PT, acc);
        wait_out(done);
        ct = out_block_s;
        checks++;
        if (ct !== FIPS_C1_CT) begin
            errors++;
            $display("FAIL nominal_ct: got %h expected %h", ct, FIPS_C1_CT);
        end
        checks++;
        if (done - acc !== 31) begin
            errors++;
            $display("FAIL nominal_latency: got %0d expected 31", done - acc);
        end
        checks++;
        if (mon_idx.size() !== 10) begin
            errors++;
            $display("FAIL nominal_pulses: got %0d expected 10", mon_idx.size());
        end
        bad = -1;
        foreach (mon_idx[i]) if (bad < 0 && mon_idx[i] != i + 1) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL nominal_rk_seq: pulse %0d rk_idx=%0d expected %0d", bad, mon_idx[bad], bad + 1);
        end
        bad = -1;
        foreach (mon_last[i]) if (bad < 0 && mon_last[i] !== (i == mon_last.size() - 1)) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL nominal_dp_last: pulse %0d dp_last=%b expected %b", bad, mon_last[bad],
                     bad == mon_last.size() - 1);
        end
        tick();
        checks++;
        if ({busy_s, in_ready_s, out_valid_s} !== 3'b010) begin
            errors++;
            $display("FAIL nominal_after_hs: {busy,in_ready,out_valid}=%b expected 010",
                     {busy_s, in_ready_s, out_valid_s});
        end
    endtask

    task automatic test_backpressure();
        int acc, done;
        sel = 0;
        out_ready = 1'b0;
        send(FIPS_PT, acc);
        wait_out(done);
        checks++;
        if (done - acc !== 31) begin
            errors++;
            $display("FAIL bp_latency: got %0d expected 31", done - acc);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_valid_s !== 1'b1 || in_ready_s !== 1'b0 || out_block_s !== FIPS_C1_CT) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b in_ready=%b block=%h expected valid=1 in_ready=0 block=%h",
                         i, out_valid_s, in_ready_s, out_block_s, FIPS_C1_CT);
            end
            tick();
        end
        out_ready = 1'b1;
        checks++;
        if (out_valid_s !== 1'b1 || out_block_s !== FIPS_C1_CT) begin
            errors++;
            $display("FAIL bp_release: valid=%b block=%h expected valid=1 block=%h",
                     out_valid_s, out_block_s, FIPS_C1_CT);
        end
        tick();
        checks++;
        if ({out_valid_s, in_ready_s, busy_s} !== 3'b010) begin
            errors++;
            $display("FAIL bp_after_hs: {out_valid,in_ready,busy}=%b expected 010",
                     {out_valid_s, in_ready_s, busy_s});
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt2, ct1, ct2, exp2;
        int acc1, acc2, done1, done2;
        sel = 0;
        out_ready = 1'b1;
        pt2 = 128'hffeeddccbbaa99887766554433221100;
        exp2 = ref_encrypt(0, pt2, 10);
        send(FIPS_PT, acc1);
        in_block = pt2;
        in_valid = 1'b1;
        wait_out(done1);
        ct1 = out_block_s;
        send(pt2, acc2);
        checks++;
        if (ct1 !== FIPS_C1_CT) begin
            errors++;
            $display("FAIL b2b_ct1: got %h expected %h", ct1, FIPS_C1_CT);
        end
        checks++;
        if (acc2 - done1 !== 1) begin
            errors++;
            $display("FAIL b2b_second_accept: got %0d cycles after output expected 1", acc2 - done1);
        end
        wait_out(done2);
        ct2 = out_block_s;
        checks++;
        if (ct2 !== exp2) begin
            errors++;
            $display("FAIL b2b_ct2: got %h expected %h", ct2, exp2);
        end
        checks++;
        if (done2 - acc2 !== 31) begin
            errors++;
            $display("FAIL b2b_latency2: got %0d expected 31", done2 - acc2);
        end
        tick();
    endtask

    task automatic test_busy_ignore();
        int acc, done;
        sel = 0;
        out_ready = 1'b1;
        send(FIPS_PT, acc);
        tick();
        in_block = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'b1;
        checks++;
        if ({busy_s, in_ready_s} !== 2'b10) begin
            errors++;
            $display("FAIL busy_ignore_ready: {busy,in_ready}=%b expected 10", {busy_s, in_ready_s});
        end
        tick();
        in_valid = 1'b0;
        wait_out(done);
        checks++;
        if (out_block_s !== FIPS_C1_CT) begin
            errors++;
            $display("FAIL busy_ignore_ct: got %h expected %h", out_block_s, FIPS_C1_CT);
        end
        checks++;
        if (done - acc !== 31) begin
            errors++;
            $display("FAIL busy_ignore_latency: got %0d expected 31", done - acc);
        end
        tick();
        tick();
        checks++;
        if ({busy_s, out_valid_s} !== 2'b00) begin
            errors++;
            $display("FAIL busy_ignore_idle: {busy,out_valid}=%b expected 00", {busy_s, out_valid_s});
        end
    endtask

    task automatic test_reset_midrun();
        int acc, done, pulses;
        sel = 0;
        out_ready = 1'b1;
        send(FIPS_PT, acc);
        pulses = 0;
        for (int i = 0; i < 100 && pulses < 5; i++) begin
            if (dp_valid_s) pulses++;
            if (pulses < 5) tick();
        end
        checks++;
        if (pulses !== 5) begin
            errors++;
            $display("FAIL midrun_reach_round5: saw %0d issues expected 5", pulses);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({busy_s, dp_valid_s, out_valid_s, in_ready_s} !== 4'b0001) begin
            errors++;
            $display("FAIL midrun_abort: {busy,dp_valid,out_valid,in_ready}=%b expected 0001",
                     {busy_s, dp_valid_s, out_valid_s, in_ready_s});
        end
        checks++;
        if (rk_idx_s !== 4'd0 || out_block_s !== 128'h0) begin
            errors++;
            $display("FAIL midrun_abort_data: rk_idx=%0d out_block=%h expected 0 and 0", rk_idx_s, out_block_s);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        send(FIPS_PT, acc);
        wait_out(done);
        checks++;
        if (out_block_s !== FIPS_C1_CT) begin
            errors++;
            $display("FAIL midrun_rerun_ct: got %h expected %h", out_block_s, FIPS_C1_CT);
        end
        checks++;
        if (done - acc !== 31) begin
            errors++;
            $display("FAIL midrun_rerun_latency: got %0d expected 31", done - acc);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [127:0] exp_ct;
        int acc, done, exp_lat, bad;
        for (int k = 1; k < NCFG; k++) begin
            sel = k;
            out_ready = 1'b1;
            mon_idx.delete();
            mon_last.delete();
            exp_ct  = (k == 1) ? FIPS_C1_CT : FIPS_C3_CT;
            exp_lat = (k == 1) ? 21 : 71;
            send(FIPS_PT, acc);
            wait_out(done);
            checks++;
            if (out_block_s !== exp_ct) begin
                errors++;
                $display("FAIL sweep_ct[%0d]: got %h expected %h", k, out_block_s, exp_ct);
            end
            checks++;
            if (done - acc !== exp_lat) begin
                errors++;
                $display("FAIL sweep_latency[%0d]: got %0d expected %0d", k, done - acc, exp_lat);
            end
            checks++;
            if (mon_idx.size() !== CFG_NR[k]) begin
                errors++;
                $display("FAIL sweep_pulses[%0d]: got %0d expected %0d", k, mon_idx.size(), CFG_NR[k]);
            end
            bad = -1;
            foreach (mon_last[i])
                if (bad < 0 && (mon_last[i] !== (i == CFG_NR[k] - 1) || mon_idx[i] != i + 1)) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL sweep_issue_seq[%0d]: pulse %0d rk_idx=%0d dp_last=%b expected rk_idx=%0d dp_last=%b",
                         k, bad, mon_idx[bad], mon_last[bad], bad + 1, bad == CFG_NR[k] - 1);
            end
            tick();
        end
        sel = 0;
    endtask

    task automatic test_random();
        logic [255:0] key;
        logic [127:0] pt, exp_ct, ct;
        int acc, done;
        sel = 0;
        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
            load_key(0, key, 4);
            pt = {$urandom, $urandom, $urandom, $urandom};
            exp_ct = ref_encrypt(0, pt, 10);
            out_ready = 1'b0;
            send(pt, acc);
            wait_out(done);
            repeat ($urandom_range(0, 3)) tick();
            ct = out_block_s;
            out_ready = 1'b1;
            checks++;
            if (ct !== exp_ct) begin
                errors++;
                $display("FAIL random_ct[%0d]: got %h expected %h", n, ct, exp_ct);
            end
            checks++;
            if (done - acc !== 31) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d expected 31", n, done - acc);
            end
            tick();
        end
    endtask

    initial begin
        load_key(0, FIPS_C1_KEY, 4);
        load_key(1, FIPS_C1_KEY, 4);
        load_key(2, FIPS_C3_KEY, 8);
        test_reset();
        test_nominal();
        test_backpressure();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midrun();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES encryption controller. It accepts a 128-bit plaintext block over a valid/ready handshake and performs the initial AddRoundKey itself. It then drives an external fixed-latency round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) NR times, fetching each round key by index from the key-schedule store. The finished ciphertext is presented on a valid/ready output.

Parameters:
NR, 10, number of rounds (10/12/14 for AES-128/192/256)
DP_LAT, 2, round-datapath latency in cycles from dp_valid to dp_result valid; legal range 1..15
RKW, 4, width of round-key index; must satisfy 2^RKW > NR

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  plaintext block offered
in_ready  output  1  block can be accepted
in_block  input  128  plaintext, byte 0 in [127:120]
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_block  output  128  ciphertext
rk_idx  output  RKW  round-key index to key store (combinational)
rk_data  input  128  round key for rk_idx, same cycle
dp_valid  output  1  one-cycle round-issue pulse
dp_state  output  128  state word into datapath
dp_key  output  128  round key into datapath (= rk_data)
dp_last  output  1  final round: datapath bypasses MixColumns
dp_result  input  128  datapath output, valid DP_LAT cycles after dp_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Registers: fsm, round (RKW bits), lat_cnt (4 bits), state_reg (128).
- Reset (async, rst=0): fsm=IDLE, round=0, lat_cnt=0, state_reg=0. Outputs while in reset: in_ready=1, out_valid=0, dp_valid=0, dp_last=0, busy=0, rk_idx=0, out_block=0.
- Reset asserted mid-operation aborts immediately. No partial output is ever produced; the next accepted block starts clean.
- IDLE: in_ready=1, rk_idx=0. On in_valid&in_ready: state_reg<=in_block^rk_data, round<=1, go to ISSUE.
- ISSUE (1 cycle):
  - dp_valid=1, dp_state=state_reg, rk_idx=round, dp_key=rk_data, dp_last=(round==NR).
  - lat_cnt<=1, go to WAIT.
- WAIT: rk_idx keeps tracking round; dp_valid=0; lat_cnt increments each cycle.
- Completion of WAIT: in the cycle where lat_cnt==DP_LAT:
  - state_reg<=dp_result.
  - If round==NR, go to DONE. Otherwise round<=round+1 and go to ISSUE.
- Round timing: each round spans DP_LAT+1 cycles. dp_valid is in cycle t, dp_result is captured at the edge ending cycle t+DP_LAT, and the next ISSUE is at t+DP_LAT+1.
- DONE:
  - out_valid=1, out_block=state_reg, held stable until out_ready.
  - On out_valid&out_ready: go to IDLE and clear round to 0.
  - in_ready stays 0 in DONE. There is no overlap of a new accept with output, so a new block is accepted one cycle after the handshake at the earliest.
- Latency: accept edge at cycle t0 gives out_valid from cycle t0+1+NR*(DP_LAT+1). With the defaults that is t0+31.
- out_block outside DONE: 0.
- dp_state and dp_key outside ISSUE: held at state_reg and rk_data (don't-care to the datapath).
- in_valid while busy is ignored. The block is not consumed, because in_ready=0.
- Key store: rk_data must be stable for the whole round. rk_idx changes only on round updates; the sequencer never modifies the key store.
- round never exceeds NR, and there is no wrap-around.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - fsm state enum (IDLE/ISSUE/WAIT/DONE).
  - constants NR_128=10, NR_192=12, NR_256=14.
  - AES_BLK_W=128.
  - the FIPS-197 test vectors, used by benches.
- One sub-module, aes_lat_timer: a loadable up-counter with a terminal-count compare against DP_LAT, producing lat_done.
- The bench supplies a behavioural round datapath with configurable DP_LAT and a key-store model.

Test Plan:
- Nominal vector: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, out_ready=1.
  - out_block=69c4e0d86a7b0430d8cdb78070b4c55a.
  - out_valid exactly 31 cycles after accept.
  - Exactly 10 dp_valid pulses; dp_last only on the 10th; rk_idx sequence 0,1..10.
- Backpressure: out_ready=0 for 20 cycles after out_valid.
  - out_block holds 69c4e0d8...c55a; in_ready=0 throughout.
  - On release, one handshake occurs, then in_ready=1 the next cycle.
- Back-to-back: two blocks offered continuously, second plaintext ffeeddccbbaa99887766554433221100.
  - Second accept occurs the cycle after the first output handshake.
  - Both ciphertexts match the reference model.
- Reset mid-run: drop rst during round 5.
  - Immediately busy=0, dp_valid=0, out_valid=0, in_ready=1.
  - The following nominal vector completes correctly.
- Parameter sweep: DP_LAT=1 with NR=10, then DP_LAT=4 with NR=14 (AES-256 vector from FIPS-197 C.3).
  - Latency is 21 and 71 cycles respectively.
  - Ciphertext for C.3 is 8ea2b7ca516745bfeafc49904b496089.
- Busy ignore: pulse in_valid with a different block during WAIT.
  - No acceptance occurs; the result is unchanged.
